rob_commit: RTL and testbench
=============================

# rob_commit

In-order retirement stage directly downstream of the 32-entry reorder buffer. Each cycle it inspects the ROB head entry and retires it when complete by pulsing `dequeue_o` to the ROB. It drives the architectural register-file write port, holds store retirement until the store queue acknowledges, and raises the pipeline-wide flush with a redirect PC on a taken/mispredicted control-flow instruction. After a flush it enforces a fixed drain window before retiring again.

## Interface
- `ROB_IDX_W`, default 5, ROB index width (32 entries).
- `FLUSH_CYCLES`, default 2, cycles spent in drain after a flush pulse (legal range 1..15).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset is asynchronous and active-low.
- `head_valid_i` input 1: ROB head entry valid.
- `head_done_i` input 1: head status is done (result written back).
- `head_rob_idx_i` input ROB_IDX_W: ROB index of head.
- `head_regf_we_i` input 1: head writes a destination register.
- `head_rd_addr_i` input 5: destination architectural register.
- `head_rd_data_i` input 32: result value.
- `head_pc_i` input 32: instruction PC.
- `head_is_store_i` input 1: head is a store.
- `head_br_en_i` input 1: head is control flow that redirects (taken; predictor is static not-taken).
- `head_pc_new_i` input 32: redirect target.
- `store_ack_i` input 1: store queue has performed the head store.
- `dequeue_o` output 1: combinational; ROB advances head at this edge.
- `store_req_o` output 1: registered; request to perform head store.
- `store_rob_idx_o` output ROB_IDX_W: registered; ROB index of requested store.
- `regf_we_o` output 1: registered; register-file write strobe.
- `regf_rd_addr_o` output 5: registered write address.
- `regf_rd_data_o` output 32: registered write data.
- `commit_rob_idx_o` output ROB_IDX_W: registered; index just retired, for RAT clear-on-match.
- `commit_valid_o` output 1: registered; one-cycle pulse per retired instruction.
- `commit_pc_o` output 32: registered PC of retired instruction.
- `order_o` output 64: retired-instruction count; wraps modulo 2^64.
- `flush_o` output 1: registered one-cycle flush pulse.
- `redirect_pc_o` output 32: registered; valid when `flush_o`=1.

## Operation
- State machine with states RUN, STORE_WAIT and DRAIN. Reset state is RUN.
- `ready` = `head_valid_i` & `head_done_i`.
- RUN:
  - `ready` & !`head_is_store_i`: `dequeue_o`=1 combinationally, and the instruction retires at the edge.
    - If `head_br_en_i`: next state is DRAIN, the drain counter loads FLUSH_CYCLES, and the flush pulse is set.
    - Otherwise remain in RUN.
  - `ready` & `head_is_store_i`: `dequeue_o`=0. Next state is STORE_WAIT; `store_req_o`<=1 and `store_rob_idx_o`<=`head_rob_idx_i`.
- STORE_WAIT:
  - `store_req_o` is held at 1 and the head is not retired until `store_ack_i`=1.
  - On the ack cycle: `dequeue_o`=1, the store retires, `store_req_o`<=0, and next state is RUN.
  - An ack received in RUN or DRAIN is ignored.
- DRAIN:
  - `dequeue_o`=0 regardless of the head.
  - The counter decrements each cycle; when it reaches 1 the next state is RUN.
  - The machine therefore spends exactly FLUSH_CYCLES cycles in DRAIN.
- Retire action, registered at the retiring edge:
  - `commit_valid_o`<=1.
  - `commit_rob_idx_o` and `commit_pc_o` are loaded from the head.
  - `regf_we_o`<=`head_regf_we_i` & (`head_rd_addr_i` != 0).
  - `regf_rd_addr_o` and `regf_rd_data_o` are loaded from the head.
  - `order_o`<=`order_o`+1.
  - Stores retire with `regf_we_o`=0 unless `head_regf_we_i` is set.
- Flush: `flush_o`<=1 and `redirect_pc_o`<=`head_pc_new_i` at the same edge as the branch retire. The branch's own writeback (JAL/JALR link) occurs on that same cycle.
- All strobe outputs (`commit_valid_o`, `regf_we_o`, `flush_o`) are 1 for exactly one cycle per event and 0 otherwise.
- Data outputs hold their last value when their strobe is 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - State RUN and drain counter 0.
  - Every registered output is 0: `store_req_o`, `store_rob_idx_o`, `regf_we_o`, `regf_rd_addr_o`, `regf_rd_data_o`, `commit_rob_idx_o`, `commit_valid_o`, `commit_pc_o`, `order_o`, `flush_o`, `redirect_pc_o`.
  - `dequeue_o`=0 while reset is asserted.
  - Reset during STORE_WAIT or DRAIN aborts immediately; no ack is expected afterwards.
- Throughput is one retire per cycle for back-to-back ready non-store heads.
- Latency:
  - `dequeue_o` is combinational in cycle N.
  - Register-file, commit and flush outputs are visible in cycle N+1.
- Stores:
  - Minimum two cycles: request in N+1, ack earliest in N+1, retire in N+1.
  - A store whose ack arrives in the cycle after the request is raised therefore retires one cycle after entering STORE_WAIT.
- `head_valid_i`=0, or `head_done_i`=0: no dequeue, no retire, state unchanged.
- ROB empty: the head is invalid, so the block is idle.
- ROB index wrap (31→0) is transparent to this block; the index is passed through unchanged.
- A flush pulse in cycle N+1 clears the ROB. Head inputs during DRAIN are don't-care.
- `order_o` 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.

## Test plan
- Reset then three ready ALU heads (rd=x1,x2,x3, data 0x11,0x22,0x33):
  - `dequeue_o` is high for 3 consecutive cycles.
  - `regf_we_o` is pulsed for 3 cycles with matching addr/data.
  - `order_o` ends at 3.
- Ready head with rd=x0, `head_regf_we_i`=1: retires with `commit_valid_o`=1 and `regf_we_o`=0; `order_o`+1.
- Ready store at idx 7, ack held off 4 cycles:
  - `store_req_o`=1 and `store_rob_idx_o`=7 for 4+ cycles.
  - `dequeue_o` fires only in the ack cycle, and `store_req_o` falls the next cycle.
- JAL at pc 0x100, `head_br_en_i`=1, `head_pc_new_i`=0x200, rd=x1, data 0x104:
  - Next cycle shows `flush_o`=1, `redirect_pc_o`=0x200, and a `regf_we_o` write of x1=0x104.
  - Then FLUSH_CYCLES=2 cycles of no dequeue even with a ready head, then normal retire.
- Head valid but not done for 5 cycles, then done: no dequeue for 5 cycles, then exactly one retire.
- Assert `rst`=0 asynchronously mid-STORE_WAIT (between clock edges):
  - `store_req_o` and all outputs drop to 0 immediately.
  - After release, state is RUN and `order_o`=0.

Source files
------------

// File: rtl/rob_commit_if.sv
// Bundle of the ROB-head, store-queue and retire-side signals around the commit stage.
// The master side is the ROB/store queue, and the slave side is rob_commit.
interface rob_commit_if #(
  parameter int ROB_IDX_W = 5
);
  logic                 head_valid_i;
  logic                 head_done_i;
  logic [ROB_IDX_W-1:0] head_rob_idx_i;
  logic                 head_regf_we_i;
  logic [4:0]           head_rd_addr_i;
  logic [31:0]          head_rd_data_i;
  logic [31:0]          head_pc_i;
  logic                 head_is_store_i;
  logic                 head_br_en_i;
  logic [31:0]          head_pc_new_i;
  logic                 store_ack_i;

  logic                 dequeue_o;
  logic                 store_req_o;
  logic [ROB_IDX_W-1:0] store_rob_idx_o;
  logic                 regf_we_o;
  logic [4:0]           regf_rd_addr_o;
  logic [31:0]          regf_rd_data_o;
  logic [ROB_IDX_W-1:0] commit_rob_idx_o;
  logic                 commit_valid_o;
  logic [31:0]          commit_pc_o;
  logic [63:0]          order_o;
  logic                 flush_o;
  logic [31:0]          redirect_pc_o;

  modport master (
    output head_valid_i, head_done_i, head_rob_idx_i, head_regf_we_i, head_rd_addr_i,
           head_rd_data_i, head_pc_i, head_is_store_i, head_br_en_i, head_pc_new_i,
           store_ack_i,
    input  dequeue_o, store_req_o, store_rob_idx_o, regf_we_o, regf_rd_addr_o,
           regf_rd_data_o, commit_rob_idx_o, commit_valid_o, commit_pc_o, order_o,
           flush_o, redirect_pc_o
  );

  modport slave (
    input  head_valid_i, head_done_i, head_rob_idx_i, head_regf_we_i, head_rd_addr_i,
           head_rd_data_i, head_pc_i, head_is_store_i, head_br_en_i, head_pc_new_i,
           store_ack_i,
    output dequeue_o, store_req_o, store_rob_idx_o, regf_we_o, regf_rd_addr_o,
           regf_rd_data_o, commit_rob_idx_o, commit_valid_o, commit_pc_o, order_o,
           flush_o, redirect_pc_o
  );
endinterface

// File: rtl/rob_commit.sv
// In-order retirement stage: retires the ROB head and drives the register-file write port.
// It also holds stores until the store queue acknowledges them, and flushes the pipeline on a redirect.
module rob_commit #(
  parameter int ROB_IDX_W    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave rob
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] STORE_WAIT = 2'd1;
  localparam logic [1:0] DRAIN      = 2'd2;

  logic [1:0]           state;
  logic [3:0]           drain_cnt;
  logic                 ready;
  logic                 deq;
  logic [ROB_IDX_W-1:0] head_idx;

  assign ready    = rob.head_valid_i & rob.head_done_i;
  assign head_idx = rob.head_rob_idx_i;

  // Stores retire only in the cycle in which the store queue acks. In DRAIN, the head is ignored.
  always_comb begin
    deq = 1'b0;
    case (state)
      RUN:        deq = ready & ~rob.head_is_store_i;
      STORE_WAIT: deq = rob.store_ack_i;
      default:    deq = 1'b0;
    endcase
  end

  assign rob.dequeue_o = deq & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= RUN;
      drain_cnt            <= 4'd0;
      rob.store_req_o      <= 1'b0;
      rob.store_rob_idx_o  <= '0;
      rob.regf_we_o        <= 1'b0;
      rob.regf_rd_addr_o   <= 5'd0;
      rob.regf_rd_data_o   <= 32'd0;
      rob.commit_rob_idx_o <= '0;
      rob.commit_valid_o   <= 1'b0;
      rob.commit_pc_o      <= 32'd0;
      rob.order_o          <= 64'd0;
      rob.flush_o          <= 1'b0;
      rob.redirect_pc_o    <= 32'd0;
    end else begin
      rob.commit_valid_o <= 1'b0;
      rob.regf_we_o      <= 1'b0;
      rob.flush_o        <= 1'b0;

      if (deq) begin
        rob.commit_valid_o   <= 1'b1;
        rob.commit_rob_idx_o <= head_idx;
        rob.commit_pc_o      <= rob.head_pc_i;
        rob.regf_we_o        <= rob.head_regf_we_i & (rob.head_rd_addr_i != 5'd0);
        rob.regf_rd_addr_o   <= rob.head_rd_addr_i;
        rob.regf_rd_data_o   <= rob.head_rd_data_i;
        rob.order_o          <= rob.order_o + 64'd1;
      end

      case (state)
        RUN: begin
          if (ready && rob.head_is_store_i) begin
            state               <= STORE_WAIT;
            rob.store_req_o     <= 1'b1;
            rob.store_rob_idx_o <= head_idx;
          end else if (ready && rob.head_br_en_i) begin
            state             <= DRAIN;
            drain_cnt         <= 4'(FLUSH_CYCLES);
            rob.flush_o       <= 1'b1;
            rob.redirect_pc_o <= rob.head_pc_new_i;
          end
        end
        STORE_WAIT: begin
          if (rob.store_ack_i) begin
            state           <= RUN;
            rob.store_req_o <= 1'b0;
          end
        end
        DRAIN: begin
          // Loaded with FLUSH_CYCLES, so leaving at 1 gives exactly FLUSH_CYCLES drain cycles
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit, with hand-computed expectations for retire, store, flush and reset.
module tb_rob_commit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rob_commit_if #(.ROB_IDX_W(5)) bus ();

  rob_commit #(.ROB_IDX_W(5), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .rob (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic done, input logic [4:0] idx,
                               input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic [31:0] pc, input logic is_store, input logic br,
                               input logic [31:0] pc_new, input logic ack);
    bus.head_valid_i    = valid;
    bus.head_done_i     = done;
    bus.head_rob_idx_i  = idx;
    bus.head_regf_we_i  = we;
    bus.head_rd_addr_i  = rd;
    bus.head_rd_data_i  = data;
    bus.head_pc_i       = pc;
    bus.head_is_store_i = is_store;
    bus.head_br_en_i    = br;
    bus.head_pc_new_i   = pc_new;
    bus.store_ack_i     = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset: a ready head must not dequeue, and every output stays zero.
    #2;
    applyStimulus(1, 1, 5'd1, 1, 5'd1, 32'h11, 32'h1000, 0, 0, 0, 0);
    #1;
    checkOutput("rst_deq", bus.dequeue_o, 0);
    step();
    checkOutput("rst_cv", bus.commit_valid_o, 0);
    checkOutput("rst_order", bus.order_o, 0);
    checkOutput("rst_req", bus.store_req_o, 0);
    checkOutput("rst_flush", bus.flush_o, 0);
    #2;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();

    // Three back-to-back ALU heads
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 1, 5'(k), 1, 5'(k), 32'(17 * k), 32'(32'h1000 + 4 * k), 0, 0, 0, 0);
      #1;
      checkOutput("alu_deq", bus.dequeue_o, 1);
      step();
      checkOutput("alu_we", bus.regf_we_o, 1);
      checkOutput("alu_addr", bus.regf_rd_addr_o, 64'(k));
      checkOutput("alu_data", bus.regf_rd_data_o, 64'(17 * k));
      checkOutput("alu_cv", bus.commit_valid_o, 1);
      checkOutput("alu_idx", bus.commit_rob_idx_o, 64'(k));
      checkOutput("alu_pc", bus.commit_pc_o, 64'(32'h1000 + 4 * k));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("idle_ack_deq", bus.dequeue_o, 0);
    step();
    checkOutput("idle_we", bus.regf_we_o, 0);
    checkOutput("idle_cv", bus.commit_valid_o, 0);
    checkOutput("idle_data_hold", bus.regf_rd_data_o, 64'h33);
    checkOutput("alu_order", bus.order_o, 3);
    checkOutput("idle_req", bus.store_req_o, 0);

    // Writes to x0 retire without a register write
    applyStimulus(1, 1, 5'd4, 1, 5'd0, 32'h44, 32'h1010, 0, 0, 0, 0);
    #1;
    checkOutput("x0_deq", bus.dequeue_o, 1);
    step();
    checkOutput("x0_cv", bus.commit_valid_o, 1);
    checkOutput("x0_we", bus.regf_we_o, 0);
    checkOutput("x0_order", bus.order_o, 4);

    // Store at idx 7; the ack is held off for 4 request cycles
    applyStimulus(1, 1, 5'd7, 0, 5'd0, 32'h0, 32'h2000, 1, 0, 0, 0);
    #1;
    checkOutput("st_deq0", bus.dequeue_o, 0);
    step();
    checkOutput("st_req", bus.store_req_o, 1);
    checkOutput("st_idx", bus.store_rob_idx_o, 7);
    checkOutput("st_cv0", bus.commit_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("st_wait_deq", bus.dequeue_o, 0);
      step();
      checkOutput("st_wait_req", bus.store_req_o, 1);
      checkOutput("st_wait_idx", bus.store_rob_idx_o, 7);
    end
    bus.store_ack_i = 1'b1;
    #1;
    checkOutput("st_ack_deq", bus.dequeue_o, 1);
    step();
    checkOutput("st_req_fall", bus.store_req_o, 0);
    checkOutput("st_cv", bus.commit_valid_o, 1);
    checkOutput("st_cidx", bus.commit_rob_idx_o, 7);
    checkOutput("st_we", bus.regf_we_o, 0);
    checkOutput("st_order", bus.order_o, 5);

    // JAL with a redirect, followed by 2 drain cycles with a ready head
    applyStimulus(1, 1, 5'd8, 1, 5'd1, 32'h104, 32'h100, 0, 1, 32'h200, 0);
    #1;
    checkOutput("jal_deq", bus.dequeue_o, 1);
    step();
    checkOutput("jal_flush", bus.flush_o, 1);
    checkOutput("jal_redirect", bus.redirect_pc_o, 64'h200);
    checkOutput("jal_we", bus.regf_we_o, 1);
    checkOutput("jal_addr", bus.regf_rd_addr_o, 1);
    checkOutput("jal_data", bus.regf_rd_data_o, 64'h104);
    checkOutput("jal_pc", bus.commit_pc_o, 64'h100);
    checkOutput("jal_order", bus.order_o, 6);
    applyStimulus(1, 1, 5'd9, 1, 5'd2, 32'h99, 32'h200, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("drain_deq", bus.dequeue_o, 0);
      step();
      checkOutput("drain_cv", bus.commit_valid_o, 0);
      checkOutput("drain_flush", bus.flush_o, 0);
    end
    #1;
    checkOutput("post_drain_deq", bus.dequeue_o, 1);
    step();
    checkOutput("post_drain_cv", bus.commit_valid_o, 1);
    checkOutput("post_drain_idx", bus.commit_rob_idx_o, 9);
    checkOutput("post_drain_order", bus.order_o, 7);

    // Head valid but not done for 5 cycles
    applyStimulus(1, 0, 5'd10, 1, 5'd3, 32'hAA, 32'h204, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("notdone_deq", bus.dequeue_o, 0);
      step();
      checkOutput("notdone_cv", bus.commit_valid_o, 0);
    end
    bus.head_done_i = 1'b1;
    #1;
    checkOutput("done_deq", bus.dequeue_o, 1);
    step();
    checkOutput("done_cv", bus.commit_valid_o, 1);
    checkOutput("done_order", bus.order_o, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("done_single", bus.commit_valid_o, 0);
    checkOutput("done_order_hold", bus.order_o, 8);

    // Asynchronous reset in the middle of STORE_WAIT
    applyStimulus(1, 1, 5'd11, 0, 5'd0, 32'h0, 32'h300, 1, 0, 0, 0);
    step();
    checkOutput("ars_req_pre", bus.store_req_o, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ars_req", bus.store_req_o, 0);
    checkOutput("ars_sidx", bus.store_rob_idx_o, 0);
    checkOutput("ars_order", bus.order_o, 0);
    checkOutput("ars_data", bus.regf_rd_data_o, 0);
    checkOutput("ars_addr", bus.regf_rd_addr_o, 0);
    checkOutput("ars_cpc", bus.commit_pc_o, 0);
    checkOutput("ars_cidx", bus.commit_rob_idx_o, 0);
    checkOutput("ars_redirect", bus.redirect_pc_o, 0);
    checkOutput("ars_deq", bus.dequeue_o, 0);
    #1;
    rst = 1'b1;
    applyStimulus(1, 1, 5'd12, 1, 5'd5, 32'h55, 32'h400, 0, 0, 0, 0);
    #1;
    checkOutput("ars_run_deq", bus.dequeue_o, 1);
    step();
    checkOutput("ars_run_cv", bus.commit_valid_o, 1);
    checkOutput("ars_run_order", bus.order_o, 1);
    checkOutput("ars_run_data", bus.regf_rd_data_o, 64'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
